// File: rtl/gcd_arb.sv
// gcd_arb: round-robin scheduler sharing one gcd core between two requesters.
// Optional RUN-state timeout is compiled in with GCD_ARB_TIMEOUT_EN.
module gcd_arb #(
  parameter int W        = 32,
  parameter int LOAD_CYC = 2,
  parameter int TIMEOUT  = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic [W-1:0] op_a0,
  input  logic [W-1:0] op_b0,
  input  logic [W-1:0] op_a1,
  input  logic [W-1:0] op_b1,
  output logic [1:0]   ack,
  output logic [W-1:0] rsp_result,
  output logic         rsp_coprime,
  output logic         rsp_err,
  output logic         busy,
  output logic         grant_id,
  output logic [W-1:0] core_a,
  output logic [W-1:0] core_b,
  output logic         core_rst_n,
  input  logic [W-1:0] core_result,
  input  logic         core_ready_n
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int LW = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;

  logic [1:0]   state_q, state_d;
  logic         last_q, last_d;
  logic         gid_q, gid_d;
  logic [1:0]   ack_q, ack_d;
  logic [W-1:0] res_q, res_d;
  logic         cop_q, cop_d;
  logic         busy_q, busy_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic         crst_q, crst_d;
  logic [LW-1:0] ld_q, ld_d;
  logic         first_q, first_d;

`ifdef GCD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  logic         gnt;
  logic [W-1:0] sel_a;
  logic [W-1:0] sel_b;

  // Round-robin pick: a lone request wins, a tie goes to the port != last.
  always_comb begin
    gnt = req[1];
    if (req == 2'b11) gnt = ~last_q;
    sel_a = gnt ? op_a1 : op_a0;
    sel_b = gnt ? op_b1 : op_b0;
  end

  // Next-state and datapath for the IDLE/LOAD/RUN/DONE sequence.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gid_d   = gid_q;
    ack_d   = 2'b00;
    res_d   = res_q;
    cop_d   = cop_q;
    busy_d  = busy_q;
    a_d     = a_q;
    b_d     = b_q;
    crst_d  = crst_q;
    ld_d    = ld_q;
    first_d = first_q;
`ifdef GCD_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        crst_d = 1'b0;
        if (|req) begin
          gid_d  = gnt;
          last_d = gnt;
          a_d    = sel_a;
          b_d    = sel_b;
          busy_d = 1'b1;
          if (sel_a == '0 || sel_b == '0) begin
            // gcd(x,0)=x and gcd(0,0)=0, so OR gives the answer.
            state_d = S_DONE;
            ack_d   = {gnt, ~gnt};
            res_d   = sel_a | sel_b;
            cop_d   = (sel_a | sel_b) == W'(1);
          end else begin
            state_d = S_LOAD;
            ld_d    = '0;
          end
        end
      end
      S_LOAD: begin
        if (ld_q == LW'(LOAD_CYC - 1)) begin
          state_d = S_RUN;
          crst_d  = 1'b1;
          first_d = 1'b1;
`ifdef GCD_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          ld_d = ld_q + LW'(1);
        end
      end
      S_RUN: begin
        first_d = 1'b0;
        // Ready seen in the first RUN cycle is left over from the last job.
        if (!first_q && !core_ready_n) begin
          state_d = S_DONE;
          ack_d   = {gid_q, ~gid_q};
          res_d   = core_result;
          cop_d   = core_result == W'(1);
          crst_d  = 1'b0;
        end
`ifdef GCD_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = S_DONE;
          ack_d   = {gid_q, ~gid_q};
          res_d   = '0;
          cop_d   = 1'b0;
          err_d   = 1'b1;
          crst_d  = 1'b0;
        end else if (cnt_q != CW'(TIMEOUT)) begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        crst_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any job in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      gid_q   <= 1'b0;
      ack_q   <= 2'b00;
      res_q   <= '0;
      cop_q   <= 1'b0;
      busy_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      crst_q  <= 1'b0;
      ld_q    <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      ack_q   <= ack_d;
      res_q   <= res_d;
      cop_q   <= cop_d;
      busy_q  <= busy_d;
      a_q     <= a_d;
      b_q     <= b_d;
      crst_q  <= crst_d;
      ld_q    <= ld_d;
      first_q <= first_d;
    end
  end

`ifdef GCD_ARB_TIMEOUT_EN
  // RUN-cycle counter and timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign ack         = ack_q;
  assign rsp_result  = res_q;
  assign rsp_coprime = cop_q;
  assign busy        = busy_q;
  assign grant_id    = gid_q;
  assign core_a      = a_q;
  assign core_b      = b_q;
  assign core_rst_n  = crst_q;

endmodule

// File: tb/tb_gcd_arb.sv
// tb_gcd_arb: random and directed traffic for gcd_arb with a behavioural
// gcd core and a cycle-level reference model of the arbiter.
module tb_gcd_arb;
  localparam int W  = 32;
  localparam int LC = 2;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   req = 2'b00;
  logic [W-1:0] op_a0 = '0, op_b0 = '0, op_a1 = '0, op_b1 = '0;
  logic [1:0]   ack;
  logic [W-1:0] rsp_result;
  logic         rsp_coprime, rsp_err, busy, grant_id;
  logic [W-1:0] core_a, core_b;
  logic         core_rst_n;
  logic [W-1:0] core_result = 32'h0000_0123;
  logic         core_ready_n = 1'b0;
  logic         stall = 1'b0;
  logic         fast = 1'b0;
  int           cdly = 0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  gcd_arb #(.W(W), .LOAD_CYC(LC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req),
    .op_a0(op_a0), .op_b0(op_b0), .op_a1(op_a1), .op_b1(op_b1),
    .ack(ack), .rsp_result(rsp_result), .rsp_coprime(rsp_coprime),
    .rsp_err(rsp_err), .busy(busy), .grant_id(grant_id),
    .core_a(core_a), .core_b(core_b), .core_rst_n(core_rst_n),
    .core_result(core_result), .core_ready_n(core_ready_n)
  );

  function automatic logic [W-1:0] gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic chkw(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0b exp=%0b t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural core: ready_n keeps its stale value while held in reset,
  // then reports gcd after a random delay.
  always @(posedge clk) begin
    if (!core_rst_n) begin
      cdly <= fast ? 0 : int'($urandom_range(0, 4));
    end else if (stall) begin
      core_ready_n <= 1'b1;
      core_result  <= 32'hdead_beef;
    end else if (cdly != 0) begin
      core_ready_n <= 1'b1;
      core_result  <= 32'hdead_beef;
      cdly         <= cdly - 1;
    end else begin
      core_ready_n <= 1'b0;
      core_result  <= gcd(core_a, core_b);
    end
  end

  logic [1:0]   req_s = 2'b00;
  logic [W-1:0] a0_s = '0, b0_s = '0, a1_s = '0, b1_s = '0;

  // What the arbiter saw on each rising edge.
  always @(posedge clk) begin
    req_s <= req;
    a0_s  <= op_a0;
    b0_s  <= op_b0;
    a1_s  <= op_a1;
    b1_s  <= op_b1;
  end

  logic         busy_p = 1'b0, active = 1'b0, byp = 1'b0;
  logic         nxt = 1'b0, tmo = 1'b0, gid = 1'b0, m_last = 1'b1;
  logic [W-1:0] ea = '0, eb = '0, er = '0;
  int           load_n = 0, run_n = 0;

  // Reference model and per-cycle comparison.
  always @(negedge clk) begin
    logic due;
    logic [W-1:0] xr;
    if (rst) begin
      busy_p = 1'b0;
      active = 1'b0;
      nxt    = 1'b0;
      tmo    = 1'b0;
      m_last = 1'b1;
    end else begin
      due = 1'b0;
      if (!busy_p) begin
        chk1("busy_rise", busy, req_s != 2'b00);
        if (req_s != 2'b00) begin
          gid    = (req_s == 2'b11) ? ~m_last : req_s[1];
          m_last = gid;
          ea     = gid ? a1_s : a0_s;
          eb     = gid ? b1_s : b0_s;
          er     = gcd(ea, eb);
          byp    = (ea == 0) || (eb == 0);
          active = 1'b1;
          nxt    = 1'b0;
          tmo    = 1'b0;
          run_n  = 0;
          load_n = 1;
          chk1("grant_id", grant_id, gid);
          chkw("core_a", core_a, ea);
          chkw("core_b", core_b, eb);
          if (byp) due = 1'b1;
          else chk1("rstn_load", core_rst_n, 1'b0);
        end else begin
          chk1("rstn_idle", core_rst_n, 1'b0);
        end
      end else if (!active) begin
        chk1("busy_idle", busy, 1'b0);
        chk1("rstn_idle", core_rst_n, 1'b0);
      end else if (nxt) begin
        due = 1'b1;
      end else begin
        chk1("busy_work", busy, 1'b1);
        chkw("core_a_hold", core_a, ea);
        chkw("core_b_hold", core_b, eb);
        if (!core_rst_n) begin
          if (run_n != 0) chk1("rstn_run", core_rst_n, 1'b1);
          else load_n++;
        end else begin
          if (run_n == 0) chkw("load_cyc", W'(load_n), W'(LC));
          run_n++;
          if (run_n >= 2 && !core_ready_n) nxt = 1'b1;
`ifdef GCD_ARB_TIMEOUT_EN
          else if (run_n == TO) begin
            nxt = 1'b1;
            tmo = 1'b1;
          end
`endif
        end
      end
      if (due) begin
        xr = tmo ? '0 : er;
        chkw("ack", W'(ack), gid ? W'(2) : W'(1));
        chkw("rsp_result", rsp_result, xr);
        chk1("rsp_coprime", rsp_coprime, xr == 1);
        chk1("rsp_err", rsp_err, tmo);
        chk1("grant_hold", grant_id, gid);
        chk1("busy_done", busy, 1'b1);
        chk1("rstn_done", core_rst_n, 1'b0);
        active = 1'b0;
        nxt    = 1'b0;
      end else begin
        chkw("ack_quiet", W'(ack), '0);
      end
      busy_p = busy;
    end
  end

  task automatic wack(input int p, input logic [W-1:0] xr, input logic xc,
                      input logic xe, output int n);
    logic got;
    got = 1'b0;
    n = 0;
    while (!got && n < 80) begin
      @(negedge clk);
      n++;
      if (ack[p]) got = 1'b1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL ack_wait port=%0d act=none exp=ack", p);
    end else begin
      chkw("lit_result", rsp_result, xr);
      chk1("lit_coprime", rsp_coprime, xc);
      chk1("lit_err", rsp_err, xe);
    end
    req[p] = 1'b0;
  endtask

  task automatic job(input int p, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] xr, input logic xc, input logic xe,
                     input int lat);
    int n;
    @(negedge clk);
    if (p == 0) begin
      op_a0 = a;
      op_b0 = b;
    end else begin
      op_a1 = a;
      op_b1 = b;
    end
    req[p] = 1'b1;
    wack(p, xr, xc, xe, n);
    if (lat > 0) chkw("latency", W'(n), W'(lat));
  endtask

  task automatic pick(output logic [W-1:0] a, output logic [W-1:0] b);
    logic [W-1:0] m;
    m = W'($urandom_range(1, 60));
    case ($urandom_range(0, 3))
      0: begin
        a = $urandom;
        b = $urandom;
      end
      1: begin
        a = '0;
        b = W'($urandom_range(0, 500));
        if ($urandom_range(0, 1) == 1) begin
          a = b;
          b = '0;
        end
      end
      default: begin
        a = m * W'($urandom_range(1, 300));
        b = m * W'($urandom_range(1, 300));
      end
    endcase
  endtask

  initial begin
    logic [1:0] pend;
    logic [W-1:0] ra, rb;
    int n, issued, acked;

    repeat (2) @(negedge clk);
    chkw("rst_ack", W'(ack), '0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_gid", grant_id, 1'b0);
    chk1("rst_rstn", core_rst_n, 1'b0);
    chkw("rst_core_a", core_a, '0);
    chkw("rst_core_b", core_b, '0);
    chkw("rst_result", rsp_result, '0);
    chk1("rst_coprime", rsp_coprime, 1'b0);
    chk1("rst_err", rsp_err, 1'b0);
    chkw("pin_gcd_a", gcd(32'd640, 32'd120), 32'd40);
    chkw("pin_gcd_b", gcd(32'd9919398, 32'd1993112), 32'd2);
    chkw("pin_gcd_c", gcd(32'd0, 32'd35), 32'd35);
    @(posedge clk);
    #2 rst = 1'b0;

    // Tie from reset: port 0 first, then port 1.
    @(negedge clk);
    op_a0 = 32'd17;
    op_b0 = 32'd3120;
    op_a1 = 32'd35;
    op_b1 = 32'd14;
    req = 2'b11;
    wack(0, 32'd1, 1'b1, 1'b0, n);
    wack(1, 32'd7, 1'b0, 1'b0, n);

    fast = 1'b1;
    job(0, 32'd10, 32'd20, 32'd10, 1'b0, 1'b0, LC + 3);
    fast = 1'b0;
    job(1, 32'd640, 32'd120, 32'd40, 1'b0, 1'b0, 0);
    job(0, 32'd9919398, 32'd1993112, 32'd2, 1'b0, 1'b0, 0);
    job(0, 32'd0, 32'd35, 32'd35, 1'b0, 1'b0, 1);
    job(1, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1);
    job(1, 32'd1, 32'd0, 32'd1, 1'b1, 1'b0, 1);

    // Abort mid-RUN with reset.
    @(negedge clk);
    op_a1 = 32'd100;
    op_b1 = 32'd75;
    req[1] = 1'b1;
    n = 0;
    while (core_rst_n !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk1("run_reached", core_rst_n, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    req = 2'b00;
    chkw("abort_ack", W'(ack), '0);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_rstn", core_rst_n, 1'b0);
    chk1("abort_gid", grant_id, 1'b0);
    chkw("abort_core_a", core_a, '0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    job(0, 32'd100, 32'd75, 32'd25, 1'b0, 1'b0, 0);

`ifdef GCD_ARB_TIMEOUT_EN
    stall = 1'b1;
    job(1, 32'd12, 32'd18, 32'd0, 1'b0, 1'b1, LC + TO + 1);
    stall = 1'b0;
    job(1, 32'd12, 32'd18, 32'd6, 1'b0, 1'b0, 0);
`endif

    // Random two-port traffic.
    pend = 2'b00;
    issued = 0;
    acked = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (pend[p] && ack[p]) begin
          req[p] = 1'b0;
          pend[p] = 1'b0;
          acked++;
        end else if (!pend[p] && c < 2800 && $urandom_range(0, 2) == 0) begin
          pick(ra, rb);
          if (p == 0) begin
            op_a0 = ra;
            op_b0 = rb;
          end else begin
            op_a1 = ra;
            op_b1 = rb;
          end
          req[p] = 1'b1;
          pend[p] = 1'b1;
          issued++;
        end
      end
    end
    chkw("all_acked", W'(acked), W'(issued));
    chkw("req_drained", W'(pend), '0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
